// File: rtl/bcd_disp_mux.sv
// Time-multiplexed 4-digit common-anode seven-segment driver.
// Scans BCD digits from a free-running refresh counter; outputs are registered.
module bcd_disp_mux #(
  parameter int N = 18
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] bcd,
  input  logic [3:0]  dp_in,
  input  logic        lzb_en,
  input  logic        blank,
  output logic [3:0]  an,
  output logic [7:0]  sseg
);

  logic [N-1:0] cnt_q, cnt_d;
  logic [3:0]   an_q, an_d;
  logic [7:0]   sseg_q, sseg_d;
  logic [1:0]   sel;
  logic [3:0]   digit;
  logic [3:0]   dig_zero;
  logic         lead_zero;

  // Active-low segment pattern {a,b,c,d,e,f,g}; codes above 9 show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111110;
    endcase
    return s;
  endfunction

  assign sel   = cnt_q[N-1:N-2];
  assign cnt_d = cnt_q + {{(N-1){1'b0}}, 1'b1};

  assign dig_zero = {bcd[15:12] == 4'd0, bcd[11:8] == 4'd0,
                     bcd[7:4]   == 4'd0, bcd[3:0]  == 4'd0};

  always_comb begin
    digit = bcd[{sel, 2'b00} +: 4];
    // A digit is leading only if it and every more significant digit are zero.
    case (sel)
      2'd3:    lead_zero = dig_zero[3];
      2'd2:    lead_zero = dig_zero[3] & dig_zero[2];
      2'd1:    lead_zero = &dig_zero[3:1];
      default: lead_zero = 1'b0;
    endcase
  end

  always_comb begin
    an_d   = ~(4'b0001 << sel);
    sseg_d = {~dp_in[sel], (lzb_en && lead_zero) ? 7'h7F : seg_decode(digit)};
    if (blank) begin
      an_d   = 4'b1111;
      sseg_d = 8'hFF;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      an_q   <= 4'b1111;
      sseg_q <= 8'hFF;
    end else begin
      cnt_q  <= cnt_d;
      an_q   <= an_d;
      sseg_q <= sseg_d;
    end
  end

  assign an   = an_q;
  assign sseg = sseg_q;

endmodule

// File: tb/tb_bcd_disp_mux.sv
// Bench for bcd_disp_mux (N=4): directed scenarios plus randomized inputs
// checked against a cycle-level behavioural model of the display.
module tb_bcd_disp_mux;
  localparam int N = 4;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b1111110, 7'b1111110,
    7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110};

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] bcd = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic        lzb_en = 1'b0;
  logic        blank = 1'b0;
  logic [3:0]  an;
  logic [7:0]  sseg;

  int checks = 0;
  int errors = 0;
  int mq = 0;

  bcd_disp_mux #(.N(N)) dut (
    .clk(clk), .reset_n(reset_n), .bcd(bcd), .dp_in(dp_in),
    .lzb_en(lzb_en), .blank(blank), .an(an), .sseg(sseg)
  );

  always #5 clk = ~clk;

  // Expected {an, sseg} after an edge, given the counter value before it.
  function automatic logic [11:0] ref_out(int q, logic [15:0] b, logic [3:0] dp,
                                          logic lz, logic bl);
    int s;
    int v;
    logic lead;
    logic [3:0] a;
    if (bl) return 12'hFFF;
    s = (q / 4) % 4;
    v = int'((b >> (4 * s)) & 16'hF);
    lead = lz && (s > 0);
    for (int j = s; j < 4; j++)
      if (((b >> (4 * j)) & 16'hF) != 0) lead = 1'b0;
    a = 4'hF;
    a[s] = 1'b0;
    return {a, ~dp[s], lead ? 7'h7F : SEG_TAB[v]};
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed an/sseg=%h required %h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag);
    logic [11:0] exp;
    exp = ref_out(mq, bcd, dp_in, lzb_en, blank);
    @(posedge clk);
    #1;
    chk(tag, {an, sseg}, exp);
    mq = (mq + 1) % 16;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mq = 0;
  endtask

  initial begin
    // Reset held
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold_a", {an, sseg}, 12'hFFF);
    bcd = 16'h1234;
    @(posedge clk);
    #1;
    chk("reset_hold_b", {an, sseg}, 12'hFFF);

    // Scan 1234 from release
    release_reset();
    step("scan_first");
    chk("scan_first_d0", {an, sseg}, {4'b1110, 8'b1_1001100});
    for (int i = 1; i < 16; i++) step("scan_1234");
    chk("scan_last_d3", {an, sseg}, {4'b0111, 8'b1_1001111});

    // Leading-zero blanking
    bcd = 16'h0050; lzb_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step("lzb_0050");
      if (i == 11) chk("lzb_d2_blank", {an, sseg}, {4'b1011, 8'hFF});
      if (i == 7)  chk("lzb_d1_five", {an, sseg}, {4'b1101, 8'b1_0100100});
    end
    bcd = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      step("lzb_0000");
      if (i == 3) chk("lzb_zero_d0", {an, sseg}, {4'b1110, 8'b1_0000001});
    end

    // Invalid code and decimal point
    bcd = 16'hA009; dp_in = 4'b0100;
    for (int i = 0; i < 16; i++) begin
      step("dp_inv");
      if (i == 11) chk("dp_d2_zero", {an, sseg}, {4'b1011, 8'b0_0000001});
      if (i == 15) chk("inv_d3_dash", {an, sseg}, {4'b0111, 8'b1_1111110});
    end

    // Global blank mid-slot with lzb_en active
    bcd = 16'h0102; dp_in = 4'b1111;
    while (mq % 4 != 2) step("pre_blank");
    blank = 1'b1;
    for (int i = 0; i < 7; i++) step("blank_on");
    chk("blank_off_state", {an, sseg}, 12'hFFF);
    blank = 1'b0;
    step("blank_resume");
    for (int i = 0; i < 8; i++) step("after_blank");

    // Asynchronous reset during the digit2 slot
    dp_in = 4'b0000; lzb_en = 1'b0; bcd = 16'h5678;
    while (mq != 10) step("pre_reset");
    chk("pre_reset_d2", {an, sseg}, {4'b1011, 8'b1_0100000});
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset", {an, sseg}, 12'hFFF);
    @(posedge clk);
    #1;
    chk("reset_mid_hold", {an, sseg}, 12'hFFF);
    release_reset();
    for (int i = 0; i < 4; i++) begin
      step("restart");
      chk("restart_d0", {an, sseg}, {4'b1110, 8'b1_0000000});
    end
    for (int i = 4; i < 16; i++) step("restart_rest");

    // Wrap over several periods
    bcd = 16'h9876; dp_in = 4'b0001;
    for (int i = 0; i < 48; i++) step("wrap");

    // Randomized inputs
    for (int blk = 0; blk < 80; blk++) begin
      logic [15:0] b;
      for (int k = 0; k < 4; k++)
        b[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      bcd    = b;
      dp_in  = 4'($urandom_range(0, 15));
      lzb_en = 1'($urandom_range(0, 1));
      blank  = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < int'($urandom_range(1, 8)); i++) step("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
